// File: rtl/branch_cmp_bht.sv
// Decode-stage branch resolution: signed branch compares, a bimodal table of
// 2-bit saturating counters for fetch prediction, and saturating branch stats.
module branch_cmp_bht #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [PC_W-1:0]   pc_f,
    output logic              pred_taken_f,
    input  logic              valid_d,
    input  logic              stall_d,
    input  logic              flush_d,
    input  logic [PC_W-1:0]   pc_d,
    input  logic              pred_taken_d,
    input  logic [5:0]        opD,
    input  logic [4:0]        rtD,
    input  logic [DATA_W-1:0] srca_d,
    input  logic [DATA_W-1:0] srcb_d,
    output logic              is_branch_d,
    output logic              taken_d,
    output logic              res_valid_o,
    output logic              res_taken_o,
    output logic              res_mispredict_o,
    output logic [CNT_W-1:0]  br_cnt_o,
    output logic [CNT_W-1:0]  mis_cnt_o
);
    localparam int BHT_N = 1 << BHT_IDX_W;

    logic [1:0]           bhtMem [BHT_N];
    logic [BHT_IDX_W-1:0] idxF;
    logic [BHT_IDX_W-1:0] idxD;
    logic                 aNeg;
    logic                 aZero;
    logic                 aEqB;
    logic                 resolve;
    logic                 unusedPcBits;

    assign idxF = pc_f[BHT_IDX_W+1:2];
    assign idxD = pc_d[BHT_IDX_W+1:2];
    assign unusedPcBits = ^{pc_f[PC_W-1:BHT_IDX_W+2], pc_f[1:0],
                            pc_d[PC_W-1:BHT_IDX_W+2], pc_d[1:0]};

    // Lookup is a plain array read, so a same-cycle update is not forwarded.
    assign pred_taken_f = bhtMem[idxF][1];

    // Sign and zero tests replace signed magnitude compares against zero.
    assign aNeg  = srca_d[DATA_W-1];
    assign aZero = (srca_d == '0);
    assign aEqB  = (srca_d == srcb_d);

    always_comb begin
        is_branch_d = 1'b0;
        taken_d     = 1'b0;
        case (opD)
            6'b000100: begin is_branch_d = 1'b1; taken_d = aEqB;          end
            6'b000101: begin is_branch_d = 1'b1; taken_d = ~aEqB;         end
            6'b000110: begin is_branch_d = 1'b1; taken_d = aNeg | aZero;  end
            6'b000111: begin is_branch_d = 1'b1; taken_d = ~aNeg & ~aZero; end
            6'b000001: begin
                case (rtD)
                    5'b00000, 5'b10000: begin is_branch_d = 1'b1; taken_d = aNeg;  end
                    5'b00001, 5'b10001: begin is_branch_d = 1'b1; taken_d = ~aNeg; end
                    default: begin is_branch_d = 1'b0; taken_d = 1'b0; end
                endcase
            end
            default: begin is_branch_d = 1'b0; taken_d = 1'b0; end
        endcase
    end

    // valid_d qualifies a decode instruction; it resolves only when neither stalled nor flushed.
    assign resolve = valid_d & is_branch_d & ~stall_d & ~flush_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < BHT_N; i++) begin
                bhtMem[i] <= 2'b01;
            end
            res_valid_o      <= 1'b0;
            res_taken_o      <= 1'b0;
            res_mispredict_o <= 1'b0;
            br_cnt_o         <= '0;
            mis_cnt_o        <= '0;
        end else begin
            res_valid_o      <= resolve;
            res_taken_o      <= resolve & taken_d;
            res_mispredict_o <= resolve & (taken_d ^ pred_taken_d);
            if (resolve) begin
                if (taken_d && bhtMem[idxD] != 2'b11) begin
                    bhtMem[idxD] <= bhtMem[idxD] + 2'b01;
                end else if (!taken_d && bhtMem[idxD] != 2'b00) begin
                    bhtMem[idxD] <= bhtMem[idxD] - 2'b01;
                end
                if (br_cnt_o != '1) begin
                    br_cnt_o <= br_cnt_o + 1'b1;
                end
                if ((taken_d ^ pred_taken_d) && mis_cnt_o != '1) begin
                    mis_cnt_o <= mis_cnt_o + 1'b1;
                end
            end
        end
    end
endmodule
